sram_line_controller: RTL and testbench

SRAM_LINE_CONTROLLER -- requirements
Module: sram_line_controller

---
 rtl/sram_line_controller.sv | 177 +++++++++++++++++
 tb/tb_sram_line_controller.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_line_controller.sv
// sram_line_controller: moves one cache line (WORDS x 16-bit) to or from an
// asynchronous SRAM, holding each word access for RW_CYCLES clocks.
// Optional feature: define SRAM_BYTE_MASK_EN to add the req_bmask port and
// per-byte write enables; without it both byte lanes follow CE_N.
// All SRAM pins are decoded from registered state only.
module sram_line_controller #(
   parameter int ADDR_W    = 20,
   parameter int WORDS     = 4,
   parameter int RW_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic                req_rw,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [16*WORDS-1:0] req_wdata,
`ifdef SRAM_BYTE_MASK_EN
   input  logic [2*WORDS-1:0]  req_bmask,
`endif
   output logic                req_ready,
   output logic                resp_valid,
   output logic [16*WORDS-1:0] resp_rdata,
   output logic                CE_N,
   output logic                OE_N,
   output logic                WE_N,
   output logic                LB_N,
   output logic                UB_N,
   output logic [19:0]         addr,
   inout  wire  [15:0]         data
);

   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int CNT_W = (RW_CYCLES > 1) ? $clog2(RW_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RW_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, RD, WR, WR_REC, DONE} state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [IDX_W-1:0]    r_idx;
   logic [CNT_W-1:0]    r_cnt;
   logic [16*WORDS-1:0] r_wdata;
   logic [16*WORDS-1:0] r_rdata;
`ifdef SRAM_BYTE_MASK_EN
   logic [2*WORDS-1:0]  r_bmask;
`endif

   logic                w_drive;
   logic                w_lb_n;
   logic                w_ub_n;
   logic                w_we_word;
   logic [15:0]         w_wword;

   // Control FSM: sequences word slots, advances the address and captures read data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_addr  <= req_addr;
                  r_idx   <= '0;
                  r_cnt   <= CNT_LOAD;
                  r_state <= req_rw ? WR : RD;
               end
            end
            RD: begin
               if (r_cnt == '0) begin
                  r_rdata[16*r_idx +: 16] <= data;
                  if (r_idx == LAST_IDX) begin
                     r_state <= DONE;
                  end else begin
                     r_idx  <= r_idx + IDX_W'(1);
                     r_addr <= r_addr + ADDR_W'(1);
                     r_cnt  <= CNT_LOAD;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            WR: begin
               if (r_cnt == '0) begin
                  r_state <= WR_REC;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            WR_REC: begin
               if (r_idx == LAST_IDX) begin
                  r_state <= DONE;
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
                  r_addr  <= r_addr + ADDR_W'(1);
                  r_cnt   <= CNT_LOAD;
                  r_state <= WR;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Request hold registers: loaded only when a request is accepted
   always_ff @(posedge clk) begin
      if (r_state == IDLE && req_valid) begin
         r_wdata <= req_wdata;
`ifdef SRAM_BYTE_MASK_EN
         r_bmask <= req_bmask;
`endif
      end
   end

   // Per-word write lane selection for the word currently in its slot
   always_comb begin
      w_wword = r_wdata[16*r_idx +: 16];
`ifdef SRAM_BYTE_MASK_EN
      w_lb_n    = ~r_bmask[2*r_idx];
      w_ub_n    = ~r_bmask[2*r_idx + 1];
      w_we_word = r_bmask[2*r_idx] | r_bmask[2*r_idx + 1];
`else
      w_lb_n    = 1'b0;
      w_ub_n    = 1'b0;
      w_we_word = 1'b1;
`endif
   end

   // SRAM strobe decode from the registered state
   always_comb begin
      CE_N    = 1'b1;
      OE_N    = 1'b1;
      WE_N    = 1'b1;
      LB_N    = 1'b1;
      UB_N    = 1'b1;
      w_drive = 1'b0;
      case (r_state)
         RD: begin
            CE_N = 1'b0;
            OE_N = 1'b0;
            LB_N = 1'b0;
            UB_N = 1'b0;
         end
         WR: begin
            CE_N    = 1'b0;
            WE_N    = ~w_we_word;
            LB_N    = w_lb_n;
            UB_N    = w_ub_n;
            w_drive = 1'b1;
         end
         WR_REC: begin
            CE_N    = 1'b0;
            LB_N    = w_lb_n;
            UB_N    = w_ub_n;
            w_drive = 1'b1;
         end
         default: ;
      endcase
   end

   // Address zero-extension to the 20-bit SRAM pin width
   always_comb begin
      addr             = '0;
      addr[ADDR_W-1:0] = r_addr;
   end

   assign data       = w_drive ? w_wword : 16'hzzzz;
   assign req_ready  = (r_state == IDLE);
   assign resp_valid = (r_state == DONE);
   assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_sram_line_controller.sv
// tb_sram_line_controller: scoreboard bench for sram_line_controller with a
// behavioural SRAM model (12 LSBs of the address select the model word).
module tb_sram_line_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_rw;
   logic [19:0] req_addr;
   logic [63:0] req_wdata;
`ifdef SRAM_BYTE_MASK_EN
   logic [7:0]  req_bmask;
`endif
   logic        req_ready;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        CE_N, OE_N, WE_N, LB_N, UB_N;
   logic [19:0] addr;
   wire  [15:0] data_bus;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] line;
      int          lat;
   } exp_t;
   exp_t sb_q[$];

   logic [63:0] last_rdata;
   logic [19:0] addr_seen[$];
   logic [31:0] we_pat, lb_pat, ub_pat;
   int          ce_cycles;

   always #5 clk = ~clk;

   sram_line_controller dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_rw     (req_rw),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
`ifdef SRAM_BYTE_MASK_EN
      .req_bmask  (req_bmask),
`endif
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .CE_N       (CE_N),
      .OE_N       (OE_N),
      .WE_N       (WE_N),
      .LB_N       (LB_N),
      .UB_N       (UB_N),
      .addr       (addr),
      .data       (data_bus)
   );

   // SRAM model
   logic [15:0] mem [0:4095];
   logic        pre_we;
   logic [11:0] pre_a;
   logic [15:0] pre_d;

   assign data_bus = (!CE_N && !OE_N && WE_N) ? mem[addr[11:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_a] <= pre_d;
      end else if (!CE_N && !WE_N) begin
         if (!LB_N) mem[addr[11:0]][7:0]  <= data_bus[7:0];
         if (!UB_N) mem[addr[11:0]][15:8] <= data_bus[15:8];
      end
   end

   task automatic preload(input logic [11:0] a, input logic [15:0] d);
      pre_a  = a;
      pre_d  = d;
      pre_we = 1'b1;
      @(posedge clk);
      #1 pre_we = 1'b0;
   endtask

   function automatic logic [63:0] model_line(input logic [11:0] a);
      return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
   endfunction

   // Drive a request (called just after a falling edge) and record its expectation
   task automatic drive_req(input logic rw, input logic [19:0] a, input logic [63:0] wd,
                            input logic [63:0] exp_line, input int exp_lat);
      exp_t e;
      req_rw    = rw;
      req_addr  = a;
      req_wdata = wd;
      req_valid = 1'b1;
      e.line = exp_line;
      e.lat  = exp_lat;
      sb_q.push_back(e);
   endtask

   // Step falling edges until resp_valid, recording pin activity; n=-1 on timeout
   task automatic wait_resp(input bit hold, input int pulse_k, output int n);
      n = -1;
      addr_seen.delete();
      we_pat = '0; lb_pat = '0; ub_pat = '0; ce_cycles = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (!hold && k == 1) req_valid = 1'b0;
         if (pulse_k != 0 && k == pulse_k) begin
            req_valid = 1'b1;
            req_rw    = 1'b1;
         end
         if (pulse_k != 0 && k == pulse_k + 1) begin
            req_valid = 1'b0;
            req_rw    = 1'b0;
         end
         if (!CE_N) begin
            ce_cycles++;
            we_pat = {we_pat[30:0], WE_N};
            lb_pat = {lb_pat[30:0], LB_N};
            ub_pat = {ub_pat[30:0], UB_N};
            if (addr_seen.size() == 0 || addr_seen[$] != addr) addr_seen.push_back(addr);
         end
         if (resp_valid) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      checks++;
      if ({CE_N, OE_N, WE_N, LB_N, UB_N} !== 5'b11111) begin
         errors++; $display("FAIL reset_strobes: got %b want 11111", {CE_N, OE_N, WE_N, LB_N, UB_N});
      end
      checks++;
      if (addr !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000", addr); end
      checks++;
      if (resp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
      rst = 1'b1;
   endtask

   task automatic test_read();
      exp_t e;
      int   n;
      preload(12'h100, 16'h1111);
      preload(12'h101, 16'h2222);
      preload(12'h102, 16'h3333);
      preload(12'h103, 16'h4444);
      @(negedge clk);
      drive_req(1'b0, 20'h00100, 64'h0, 64'h4444_3333_2222_1111, 9);
      wait_resp(1'b0, 0, n);
      e = sb_q.pop_front();
      checks++;
      if (n !== e.lat) begin errors++; $display("FAIL read_latency: got %0d want %0d", n, e.lat); end
      checks++;
      if (resp_rdata !== e.line) begin errors++; $display("FAIL read_data: got %h want %h", resp_rdata, e.line); end
      last_rdata = e.line;
      checks++;
      if (addr_seen.size() !== 4) begin
         errors++; $display("FAIL read_addr_count: got %0d want 4", addr_seen.size());
      end else begin
         checks++;
         if ({addr_seen[0], addr_seen[1], addr_seen[2], addr_seen[3]} !== {20'h00100, 20'h00101, 20'h00102, 20'h00103}) begin
            errors++; $display("FAIL read_addr_seq: got %h %h %h %h want 00100..00103",
                               addr_seen[0], addr_seen[1], addr_seen[2], addr_seen[3]);
         end
      end
      checks++;
      if ({ce_cycles, we_pat[7:0]} !== {32'd8, 8'hFF}) begin
         errors++; $display("FAIL read_strobes: got ce=%0d we=%h want ce=8 we=ff", ce_cycles, we_pat[7:0]);
      end
   endtask

   task automatic test_write();
      exp_t e;
      int   n;
      @(negedge clk);
      drive_req(1'b1, 20'h00200, 64'hDDDD_CCCC_BBBB_AAAA, last_rdata, 13);
      wait_resp(1'b0, 0, n);
      e = sb_q.pop_front();
      checks++;
      if (n !== e.lat) begin errors++; $display("FAIL write_latency: got %0d want %0d", n, e.lat); end
      checks++;
      if (resp_rdata !== e.line) begin errors++; $display("FAIL write_rdata_kept: got %h want %h", resp_rdata, e.line); end
      checks++;
      if ({ce_cycles, we_pat[11:0]} !== {32'd12, 12'h249}) begin
         errors++; $display("FAIL write_we_pattern: got ce=%0d we=%h want ce=12 we=249", ce_cycles, we_pat[11:0]);
      end
      checks++;
      if ({lb_pat[11:0], ub_pat[11:0]} !== 24'h0) begin
         errors++; $display("FAIL write_byte_lanes: got lb=%h ub=%h want 000 000", lb_pat[11:0], ub_pat[11:0]);
      end
      checks++;
      if ({mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]} !== 64'hDDDD_CCCC_BBBB_AAAA) begin
         errors++; $display("FAIL write_mem: got %h %h %h %h want dddd cccc bbbb aaaa",
                            mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]);
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      int   n;
      preload(12'hFFE, 16'hA0A0);
      preload(12'hFFF, 16'hB1B1);
      preload(12'h000, 16'hC2C2);
      preload(12'h001, 16'hD3D3);
      @(negedge clk);
      drive_req(1'b0, 20'hFFFFE, 64'h0, 64'hD3D3_C2C2_B1B1_A0A0, 9);
      wait_resp(1'b0, 0, n);
      e = sb_q.pop_front();
      checks++;
      if (n !== e.lat) begin errors++; $display("FAIL wrap_latency: got %0d want %0d", n, e.lat); end
      checks++;
      if (resp_rdata !== e.line) begin errors++; $display("FAIL wrap_data: got %h want %h", resp_rdata, e.line); end
      last_rdata = e.line;
      checks++;
      if (addr_seen.size() !== 4) begin
         errors++; $display("FAIL wrap_addr_count: got %0d want 4", addr_seen.size());
      end else begin
         checks++;
         if ({addr_seen[0], addr_seen[1], addr_seen[2], addr_seen[3]} !== {20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001}) begin
            errors++; $display("FAIL wrap_addr_seq: got %h %h %h %h want ffffe fffff 00000 00001",
                               addr_seen[0], addr_seen[1], addr_seen[2], addr_seen[3]);
         end
      end
   endtask

`ifdef SRAM_BYTE_MASK_EN
   task automatic test_byte_mask();
      exp_t e;
      int   n;
      for (int i = 0; i < 4; i++) preload(12'h300 + 12'(i), 16'h5A5A);
      @(negedge clk);
      req_bmask = 8'b00_01_10_11;
      drive_req(1'b1, 20'h00300, 64'h4444_3333_2222_1111, last_rdata, 13);
      wait_resp(1'b0, 0, n);
      e = sb_q.pop_front();
      req_bmask = 8'hFF;
      checks++;
      if (n !== e.lat) begin errors++; $display("FAIL bmask_latency: got %0d want %0d", n, e.lat); end
      checks++;
      if (we_pat[11:0] !== 12'h24F) begin errors++; $display("FAIL bmask_we: got %h want 24f", we_pat[11:0]); end
      checks++;
      if ({lb_pat[11:0], ub_pat[11:0]} !== {12'h1C7, 12'h03F}) begin
         errors++; $display("FAIL bmask_lanes: got lb=%h ub=%h want 1c7 03f", lb_pat[11:0], ub_pat[11:0]);
      end
      checks++;
      if ({mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]} !== 64'h5A5A_5A33_225A_1111) begin
         errors++; $display("FAIL bmask_mem: got %h %h %h %h want 5a5a 5a33 225a 1111",
                            mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]);
      end
   endtask
`endif

   task automatic test_back_to_back();
      exp_t e;
      int   n;
      bit   busy;
      @(negedge clk);
      drive_req(1'b0, 20'h00100, 64'h0, model_line(12'h100), 9);
      wait_resp(1'b1, 0, n);
      e = sb_q.pop_front();
      checks++;
      if (n !== e.lat) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", n, e.lat); end
      checks++;
      if (resp_rdata !== e.line) begin errors++; $display("FAIL b2b_first_data: got %h want %h", resp_rdata, e.line); end
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done: got %b want 0", req_ready); end
      // request still held; the next IDLE cycle accepts it
      @(negedge clk);
      checks++;
      if ({req_ready, CE_N, resp_valid} !== 3'b110) begin
         errors++; $display("FAIL b2b_idle_gap: got ready/ce_n/resp=%b want 110", {req_ready, CE_N, resp_valid});
      end
      drive_req(1'b0, 20'h00100, 64'h0, model_line(12'h100), 9);
      wait_resp(1'b0, 3, n);
      e = sb_q.pop_front();
      checks++;
      if (n !== e.lat) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", n, e.lat); end
      checks++;
      if (resp_rdata !== e.line) begin errors++; $display("FAIL b2b_second_data: got %h want %h", resp_rdata, e.line); end
      last_rdata = e.line;
      checks++;
      if ({ce_cycles, we_pat[7:0]} !== {32'd8, 8'hFF}) begin
         errors++; $display("FAIL b2b_pulse_in_rd: got ce=%0d we=%h want ce=8 we=ff", ce_cycles, we_pat[7:0]);
      end
      busy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!CE_N || resp_valid) busy = 1'b1;
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored_req: got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_abort();
      int  falls;
      bit  prev_we;
      bit  seen_resp;
      preload(12'h282, 16'h0BAD);
      @(negedge clk);
      drive_req(1'b1, 20'h00280, 64'h9999_8888_7777_6666, 64'h0, 0);
      falls   = 0;
      prev_we = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         if (prev_we && !WE_N) falls++;
         prev_we = WE_N;
         if (falls == 3) break;
      end
      checks++;
      if (falls !== 3) begin errors++; $display("FAIL abort_third_word: got %0d WE_N falls want 3", falls); end
      // aborted transfer produces no response
      void'(sb_q.pop_back());
      rst = 1'b0;
      #1;
      checks++;
      if ({CE_N, OE_N, WE_N, LB_N, UB_N} !== 5'b11111) begin
         errors++; $display("FAIL abort_strobes: got %b want 11111", {CE_N, OE_N, WE_N, LB_N, UB_N});
      end
      checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         errors++; $display("FAIL abort_resp_ready: got %b want 01", {resp_valid, req_ready});
      end
      checks++;
      if (resp_rdata !== 64'h0) begin errors++; $display("FAIL abort_rdata: got %h want 0", resp_rdata); end
      last_rdata = 64'h0;
      @(negedge clk);
      rst = 1'b1;
      seen_resp = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (resp_valid || !CE_N) seen_resp = 1'b1;
      end
      checks++;
      if (seen_resp !== 1'b0) begin errors++; $display("FAIL abort_no_resp: got activity=%b want 0", seen_resp); end
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_after: got %b want 1", req_ready); end
      checks++;
      if ({mem[12'h282], mem[12'h281], mem[12'h280]} !== 48'h0BAD_7777_6666) begin
         errors++; $display("FAIL abort_mem: got %h %h %h want 0bad 7777 6666",
                            mem[12'h282], mem[12'h281], mem[12'h280]);
      end
      checks++;
      if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: got %0d left want 0", sb_q.size()); end
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_rw    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      pre_we    = 1'b0;
      pre_a     = '0;
      pre_d     = '0;
`ifdef SRAM_BYTE_MASK_EN
      req_bmask = 8'hFF;
`endif
      last_rdata = '0;
      test_reset();
      test_read();
      test_write();
      test_wrap();
`ifdef SRAM_BYTE_MASK_EN
      test_byte_mask();
`endif
      test_back_to_back();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
